// File: rtl/noise_frame_scheduler.sv
// Raster scheduler for the fixed-latency noise core, plus its small result FIFO.

// Result FIFO with the head entry always visible (first-word-fall-through).
// Latency: a push is visible at the head on the next cycle.
// Backpressure: count reports occupancy. Push and pop together are allowed when full.
module noise_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Issues (x,y,t) in raster order, tags in-flight samples and buffers core results.
// Latency: a coordinate reaches the out stream LATENCY+1 cycles after it is presented.
// Backpressure: issue stalls on FIFO credit, because the noise core cannot be stalled.
module noise_frame_scheduler #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [3:0]  speed,
  input  logic        t_load,
  input  logic [15:0] t_load_val,
  output logic [9:0]  noise_x,
  output logic [9:0]  noise_y,
  output logic [15:0] noise_t,
  input  logic [7:0]  noise_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic        out_last,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [9:0] x;
    logic [9:0] y;
  } tag_t;

  typedef struct packed {
    logic       last;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] data;
  } sample_t;

  localparam int         FCW    = $clog2(FIFO_DEPTH+1);
  localparam int         CW     = $clog2(FIFO_DEPTH+LATENCY+1) + 1;
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE-1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE-1);

  state_t         state;
  logic [15:0]    t_reg;
  tag_t           pipe [LATENCY];
  tag_t           next_tag;
  sample_t        push_sample;
  sample_t        head;
  logic [FCW-1:0] fifo_count;
  logic [CW-1:0]  inflight;
  logic           pop;
  logic           issue;
  logic           at_last;
  logic           last_pop;

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign last_pop   = pop && head.last && (state == DRAIN);
  assign frame_done = last_pop;
  assign at_last    = (noise_x == X_LAST) && (noise_y == Y_LAST);

  // Head fields read as zero when the FIFO is empty so reset leaves every output at 0.
  assign out_data = out_valid ? head.data : '0;
  assign out_x    = out_valid ? head.x    : '0;
  assign out_y    = out_valid ? head.y    : '0;
  assign out_last = out_valid && head.last;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe[i].vld);
    end
  end

  // A pop this cycle frees its slot at once, which keeps one issue per cycle with LATENCY+1 entries.
  assign issue = (state == ISSUE) &&
                 ((inflight + CW'(fifo_count) - CW'(pop)) < CW'(FIFO_DEPTH));

  always_comb begin
    next_tag      = '0;
    next_tag.vld  = issue;
    next_tag.last = at_last;
    next_tag.x    = noise_x;
    next_tag.y    = noise_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= next_tag;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    push_sample      = '0;
    push_sample.last = pipe[LATENCY-1].last;
    push_sample.x    = pipe[LATENCY-1].x;
    push_sample.y    = pipe[LATENCY-1].y;
    push_sample.data = noise_in;
  end

  noise_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pipe[LATENCY-1].vld),
    .push_dat (push_sample),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  // noise_x/noise_y double as the raster cursor. The last coordinate is never stepped past, so it persists in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      noise_x <= '0;
      noise_y <= '0;
      noise_t <= '0;
      t_reg   <= '0;
      busy    <= 1'b0;
    end else begin
      if (t_load) begin
        t_reg <= t_load_val;
      end else if (last_pop && !pause) begin
        t_reg <= t_reg + 16'(speed);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            noise_t <= t_reg;
            noise_x <= '0;
            noise_y <= '0;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (at_last) begin
              state <= DRAIN;
            end else if (noise_x == X_LAST) begin
              noise_x <= '0;
              noise_y <= noise_y + 10'd1;
            end else begin
              noise_x <= noise_x + 10'd1;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
